traffic_road_model: RTL
=======================

TRAFFIC_ROAD_MODEL -- requirements
Module: traffic_road_model

Interface
REQ-001 Parameter QMAX, default 15: maximum cars held in each road queue.
REQ-002 Parameter MIN_GREEN_A, default 6: minimum consecutive green cycles on road A.
REQ-003 Parameter MIN_GREEN_B, default 5: minimum consecutive green cycles on road B.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- red_A, yellow_A, green_A  in  1 each  road A lamps from the controller
- red_B, yellow_B, green_B  in  1 each  road B lamps from the controller
- arrive_A, arrive_B  in  1 each  one-cycle car-arrival pulse per road
- sensor_A, sensor_B  out  sensor_state_e  CARS/NO_CARS fed back to the controller
- queue_A, queue_B  out  $clog2(QMAX+1)  cars waiting per road
- overflow_A, overflow_B  out  1  sticky: an arrival was dropped
- violation  out  1  sticky: lamp protocol breach detected
- violation_code  out  3  first breach recorded
- passed_A, passed_B  out  16  cars departed (feature-gated, REQ-022)

Function
REQ-005 Inputs SHALL be sampled on posedge clk; all outputs are registered or decoded from registers only.
REQ-006 Per-road light decode: exactly one lamp on gives R/Y/G; any other combination is ILLEGAL.
REQ-007 Departure SHALL occur in a cycle when the road decodes G and its queue is >0 at that edge; at most one departure per road per cycle; no departure on Y or R.
REQ-008 Next queue = queue + arrival - departure, with these boundary cases:
- arrival+departure together: unchanged
- queue 0, green, arrival: becomes 1
- queue QMAX, arrival, no departure: stays QMAX and sets overflow
- queue QMAX, arrival+departure: stays QMAX, no overflow
REQ-009 sensor_X SHALL be CARS when queue_X > 0, otherwise NO_CARS.
REQ-010 Each road keeps its previous decoded state prev_X in {NONE, R, Y, G}.
- Legal transitions: G->G, G->Y, Y->R, R->R, R->G, and NONE->any.
- Illegal transitions: G->R, R->Y, Y->G, Y->Y.
REQ-011 Each road keeps an 8-bit saturating green-run counter.
- Loads 1 on entry to G.
- Increments each further G cycle.
- Clears otherwise.
REQ-012 Breach codes SHALL be:
- 1: ILLEGAL encoding on either road
- 2: both roads non-R in the same cycle
- 3: illegal transition
- 4: G->Y with green-run < MIN_GREEN_X
REQ-013 If several codes fire in one cycle, the lowest code wins.
REQ-014 On the first breach, violation=1 and violation_code SHALL be set at the same edge; both hold until reset, and later breaches are ignored.
REQ-015 Breach latency SHALL be one cycle: offending lamps at edge N give violation=1 after edge N.
REQ-016 Road A and road B logic SHALL operate independently except for code 2.

Reset
REQ-017 When rst asserts, all of these SHALL clear asynchronously: queues=0, sensors=NO_CARS, overflow_A/B=0, violation=0, violation_code=0, prev_A/B=NONE, green-run counters=0, passed_A/B=0.
REQ-018 rst asserted mid-operation SHALL discard queued cars and sticky flags.
REQ-019 The first sampled cycle after rst deasserts SHALL skip transition checks; encoding and conflict checks still apply.
REQ-020 Arrivals while rst is high SHALL be ignored.

Configuration
REQ-021 The macro TRAFFIC_MODEL_STATS_EN SHALL compile the departure statistics in or out.
REQ-022 With TRAFFIC_MODEL_STATS_EN defined, passed_A/B SHALL each increment once per departure and saturate at 16'hFFFF.
REQ-023 Without TRAFFIC_MODEL_STATS_EN, passed_A/B SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-024 Reset, lamps A=G/B=R, arrive_B pulsed 3 cycles -> queue_B=3, sensor_B=CARS, queue_A=0, violation=0.
REQ-025 A=G/B=R for 6 cycles, A=Y one cycle, then A=R/B=G for 5 cycles, no arrivals -> violation stays 0.
REQ-026 queue_A=15 (QMAX), A=R, arrive_A=1 -> queue_A=15, overflow_A=1 next cycle; then A=G with arrive_A=1 -> queue_A stays 15.
REQ-027 A=G for 3 cycles, then A=Y -> violation=1, violation_code=4; a later G->R on road B leaves code at 4.
REQ-028 Same cycle: green_A=1, yellow_A=1, green_B=1 -> violation_code=1, not 2.
REQ-029 Stats build: road B green 4 cycles with queue_B=2 -> passed_B=2, queue_B=0, sensor_B=NO_CARS; non-stats build -> passed_B=0.

Source files
------------

// File: rtl/traffic_road_model.sv
// rtl/traffic_road_model.sv - two-road traffic model: car queues, lamp decode and protocol breach monitor
// Optional departure statistics compiled in with TRAFFIC_MODEL_STATS_EN.
package traffic_road_model_pkg;
    typedef enum logic {NO_CARS = 1'b0, CARS = 1'b1} sensor_state_e;
endpackage

module traffic_road_model #(
    parameter int QMAX        = 15,
    parameter int MIN_GREEN_A = 6,
    parameter int MIN_GREEN_B = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  red_A,
    input  logic                                  yellow_A,
    input  logic                                  green_A,
    input  logic                                  red_B,
    input  logic                                  yellow_B,
    input  logic                                  green_B,
    input  logic                                  arrive_A,
    input  logic                                  arrive_B,
    output traffic_road_model_pkg::sensor_state_e sensor_A,
    output traffic_road_model_pkg::sensor_state_e sensor_B,
    output logic [$clog2(QMAX+1)-1:0]             queue_A,
    output logic [$clog2(QMAX+1)-1:0]             queue_B,
    output logic                                  overflow_A,
    output logic                                  overflow_B,
    output logic                                  violation,
    output logic [2:0]                            violation_code,
    output logic [15:0]                           passed_A,
    output logic [15:0]                           passed_B
);
    import traffic_road_model_pkg::*;

    localparam int         QW      = $clog2(QMAX + 1);
    localparam logic [7:0] MGA     = 8'(MIN_GREEN_A);
    localparam logic [7:0] MGB     = 8'(MIN_GREEN_B);
    localparam logic [QW-1:0] QFULL = QW'(QMAX);

    typedef enum logic [1:0] {L_NONE, L_R, L_Y, L_G} lamp_e;

    // Illegal lamp combinations decode to L_NONE, so the next cycle skips transition checks.
    function automatic lamp_e decode(input logic r, input logic y, input logic g);
        case ({r, y, g})
            3'b100:  return L_R;
            3'b010:  return L_Y;
            3'b001:  return L_G;
            default: return L_NONE;
        endcase
    endfunction

    function automatic logic bad_trans(input lamp_e p, input lamp_e c);
        return (p == L_G && c == L_R) || (p == L_R && c == L_Y) ||
               (p == L_Y && (c == L_G || c == L_Y));
    endfunction

    logic [QW-1:0] queue_a_q, queue_a_d, queue_b_q, queue_b_d;
    logic          ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    lamp_e         prev_a_q, prev_b_q, cur_a, cur_b;
    logic [7:0]    run_a_q, run_a_d, run_b_q, run_b_d;
    logic          viol_q;
    logic [2:0]    code_q, code_d;
    logic          ill_a, ill_b, dep_a, dep_b;

    always_comb begin
        cur_a = decode(red_A, yellow_A, green_A);
        cur_b = decode(red_B, yellow_B, green_B);
        ill_a = ({red_A, yellow_A, green_A} != 3'b100) && ({red_A, yellow_A, green_A} != 3'b010) &&
                ({red_A, yellow_A, green_A} != 3'b001);
        ill_b = ({red_B, yellow_B, green_B} != 3'b100) && ({red_B, yellow_B, green_B} != 3'b010) &&
                ({red_B, yellow_B, green_B} != 3'b001);
        dep_a = (cur_a == L_G) && (queue_a_q != '0);
        dep_b = (cur_b == L_G) && (queue_b_q != '0);

        queue_a_d = queue_a_q;
        ovf_a_d   = ovf_a_q;
        if (arrive_A && !dep_a) begin
            if (queue_a_q == QFULL) ovf_a_d = 1'b1;
            else                    queue_a_d = queue_a_q + 1'b1;
        end else if (dep_a && !arrive_A) begin
            queue_a_d = queue_a_q - 1'b1;
        end

        queue_b_d = queue_b_q;
        ovf_b_d   = ovf_b_q;
        if (arrive_B && !dep_b) begin
            if (queue_b_q == QFULL) ovf_b_d = 1'b1;
            else                    queue_b_d = queue_b_q + 1'b1;
        end else if (dep_b && !arrive_B) begin
            queue_b_d = queue_b_q - 1'b1;
        end

        run_a_d = 8'd0;
        if (cur_a == L_G) run_a_d = (prev_a_q != L_G) ? 8'd1 : (run_a_q == 8'hFF) ? run_a_q : run_a_q + 8'd1;
        run_b_d = 8'd0;
        if (cur_b == L_G) run_b_d = (prev_b_q != L_G) ? 8'd1 : (run_b_q == 8'hFF) ? run_b_q : run_b_q + 8'd1;

        // Lowest code wins when several breaches coincide.
        if (ill_a || ill_b)                                          code_d = 3'd1;
        else if (cur_a != L_R && cur_b != L_R)                       code_d = 3'd2;
        else if (bad_trans(prev_a_q, cur_a) || bad_trans(prev_b_q, cur_b)) code_d = 3'd3;
        else if ((prev_a_q == L_G && cur_a == L_Y && run_a_q < MGA) ||
                 (prev_b_q == L_G && cur_b == L_Y && run_b_q < MGB)) code_d = 3'd4;
        else                                                         code_d = 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue_a_q <= '0;
            queue_b_q <= '0;
            ovf_a_q   <= 1'b0;
            ovf_b_q   <= 1'b0;
            prev_a_q  <= L_NONE;
            prev_b_q  <= L_NONE;
            run_a_q   <= 8'd0;
            run_b_q   <= 8'd0;
            viol_q    <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            queue_a_q <= queue_a_d;
            queue_b_q <= queue_b_d;
            ovf_a_q   <= ovf_a_d;
            ovf_b_q   <= ovf_b_d;
            prev_a_q  <= cur_a;
            prev_b_q  <= cur_b;
            run_a_q   <= run_a_d;
            run_b_q   <= run_b_d;
            if (!viol_q && code_d != 3'd0) begin
                viol_q <= 1'b1;
                code_q <= code_d;
            end
        end
    end

`ifdef TRAFFIC_MODEL_STATS_EN
    logic [15:0] passed_a_q, passed_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            passed_a_q <= 16'd0;
            passed_b_q <= 16'd0;
        end else begin
            if (dep_a && passed_a_q != 16'hFFFF) passed_a_q <= passed_a_q + 16'd1;
            if (dep_b && passed_b_q != 16'hFFFF) passed_b_q <= passed_b_q + 16'd1;
        end
    end

    assign passed_A = passed_a_q;
    assign passed_B = passed_b_q;
`else
    assign passed_A = 16'd0;
    assign passed_B = 16'd0;
`endif

    assign queue_A        = queue_a_q;
    assign queue_B        = queue_b_q;
    assign sensor_A       = (queue_a_q != '0) ? CARS : NO_CARS;
    assign sensor_B       = (queue_b_q != '0) ? CARS : NO_CARS;
    assign overflow_A     = ovf_a_q;
    assign overflow_B     = ovf_b_q;
    assign violation      = viol_q;
    assign violation_code = code_q;
endmodule
